// File: rtl/ethernet_frame_unpadding_512.sv
// Strips Ethernet minimum-size padding from IPv4 frames on a 512-bit AXI-Stream path.
// Optional frame statistics counters are enabled with the ETH_UNPAD_STATS_EN macro.
module ethernet_frame_unpadding_512 #(
  parameter int STAT_WIDTH = 32
) (
  input  logic                  net_clk,
  input  logic                  sys_reset,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [511:0]          s_axis_tdata,
  input  logic [63:0]           s_axis_tkeep,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [511:0]          m_axis_tdata,
  output logic [63:0]           m_axis_tkeep,
  output logic                  m_axis_tlast
`ifdef ETH_UNPAD_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_trimmed,
  output logic [STAT_WIDTH-1:0] stat_short,
  output logic [STAT_WIDTH-1:0] stat_passthru
`endif
);

  // state    | meaning
  // IDLE     | waiting for the first beat of a frame (header parse)
  // PASS     | forwarding a non-trimmable frame unchanged
  // TRIM     | IPv4 frame, R bytes still belong to the frame
  // DISCARD  | frame already closed, swallowing padding beats
  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_TRIM, ST_DISCARD} state_t;

  state_t         r_state;
  logic [16:0]    r_rem;
  logic           r_m_tvalid;
  logic [511:0]   r_m_tdata;
  logic [63:0]    r_m_tkeep;
  logic           r_m_tlast;

  logic           w_accept;
  logic [15:0]    w_ethertype;
  logic [15:0]    w_ip_len;
  logic           w_hdr_trim;
  logic [16:0]    w_frame_len;
  logic           w_in_trim;
  logic [16:0]    w_rem;
  logic           w_fits;
  logic           w_cut;
  logic           w_emit;
  logic [63:0]    w_len_mask;
  logic [63:0]    w_out_keep;
  logic           w_out_last;
  logic [5:0]     w_last_idx;
  state_t         w_next_state;

  assign s_axis_tready = !sys_reset &&
                         ((r_state == ST_DISCARD) || m_axis_tready || !r_m_tvalid);
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  assign w_ethertype = {s_axis_tdata[12*8 +: 8], s_axis_tdata[13*8 +: 8]};
  assign w_ip_len    = {s_axis_tdata[16*8 +: 8], s_axis_tdata[17*8 +: 8]};
  assign w_hdr_trim  = (w_ethertype == 16'h0800) && (w_ip_len >= 16'd20);
  assign w_frame_len = 17'd14 + {1'b0, w_ip_len};

  assign w_in_trim = (r_state == ST_IDLE) ? w_hdr_trim : (r_state == ST_TRIM);
  assign w_rem     = (r_state == ST_IDLE) ? w_frame_len : r_rem;
  assign w_fits    = (w_rem <= 17'd64);
  assign w_cut     = w_in_trim && w_fits;
  assign w_emit    = (r_state != ST_DISCARD);
  assign w_last_idx = w_rem[5:0] - 6'd1;

  always_comb begin
    w_len_mask = '0;
    for (int i = 0; i < 64; i++) begin
      w_len_mask[i] = (17'(i) < w_rem);
    end
  end

  // Cut only ever clears keep bits; data bytes always pass through untouched
  assign w_out_keep = w_cut ? (s_axis_tkeep & w_len_mask) : s_axis_tkeep;
  assign w_out_last = w_cut ? 1'b1 : s_axis_tlast;

  always_comb begin
    w_next_state = r_state;
    if (r_state == ST_DISCARD) begin
      w_next_state = s_axis_tlast ? ST_IDLE : ST_DISCARD;
    end else if (w_cut) begin
      w_next_state = s_axis_tlast ? ST_IDLE : ST_DISCARD;
    end else if (w_in_trim) begin
      w_next_state = s_axis_tlast ? ST_IDLE : ST_TRIM;
    end else begin
      w_next_state = s_axis_tlast ? ST_IDLE : ST_PASS;
    end
  end

  always_ff @(posedge net_clk) begin
    if (sys_reset) begin
      r_state    <= ST_IDLE;
      r_rem      <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
    end else begin
      if (m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end
      if (w_accept) begin
        r_state <= w_next_state;
        if (w_in_trim && !w_fits) begin
          r_rem <= w_rem - 17'd64;
        end
        if (w_emit) begin
          r_m_tvalid <= 1'b1;
          r_m_tdata  <= s_axis_tdata;
          r_m_tkeep  <= w_out_keep;
          r_m_tlast  <= w_out_last;
        end
      end
    end
  end

  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_tlast  = r_m_tlast;

`ifdef ETH_UNPAD_STATS_EN
  logic                  w_ev_trimmed;
  logic                  w_ev_short;
  logic                  w_ev_passthru;
  logic [STAT_WIDTH-1:0] r_stat_trimmed;
  logic [STAT_WIDTH-1:0] r_stat_short;
  logic [STAT_WIDTH-1:0] r_stat_passthru;

  // Exact fit (frame ends precisely at F) counts as neither trimmed nor short
  assign w_ev_trimmed  = w_accept && w_cut &&
                         (!s_axis_tlast || ((w_rem != 17'd64) && s_axis_tkeep[w_rem[5:0]]));
  assign w_ev_short    = w_accept && w_in_trim && s_axis_tlast &&
                         (!w_fits || !s_axis_tkeep[w_last_idx]);
  assign w_ev_passthru = w_accept && (r_state == ST_IDLE) && !w_hdr_trim;

  always_ff @(posedge net_clk) begin
    if (sys_reset) begin
      r_stat_trimmed  <= '0;
      r_stat_short    <= '0;
      r_stat_passthru <= '0;
    end else begin
      if (w_ev_trimmed && (r_stat_trimmed != '1)) begin
        r_stat_trimmed <= r_stat_trimmed + 1'b1;
      end
      if (w_ev_short && (r_stat_short != '1)) begin
        r_stat_short <= r_stat_short + 1'b1;
      end
      if (w_ev_passthru && (r_stat_passthru != '1)) begin
        r_stat_passthru <= r_stat_passthru + 1'b1;
      end
    end
  end

  assign stat_trimmed  = r_stat_trimmed;
  assign stat_short    = r_stat_short;
  assign stat_passthru = r_stat_passthru;
`endif

endmodule

// File: tb/tb_ethernet_frame_unpadding_512.sv
// Bench for ethernet_frame_unpadding_512: frame-level reference model, per-cycle output compare,
// directed corner frames, reset mid-frame and randomized traffic with output back-pressure.
module tb_ethernet_frame_unpadding_512;

  logic         net_clk;
  logic         sys_reset;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast;
`ifdef ETH_UNPAD_STATS_EN
  logic [31:0]  stat_trimmed;
  logic [31:0]  stat_short;
  logic [31:0]  stat_passthru;
`endif

  ethernet_frame_unpadding_512 #(.STAT_WIDTH(32)) dut (
    .net_clk       (net_clk),
    .sys_reset     (sys_reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast)
`ifdef ETH_UNPAD_STATS_EN
    ,
    .stat_trimmed  (stat_trimmed),
    .stat_short    (stat_short),
    .stat_passthru (stat_passthru)
`endif
  );

  initial begin
    net_clk = 1'b0;
    forever #5 net_clk = ~net_clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  logic [511:0] exp_d[$];
  logic [63:0]  exp_k[$];
  logic         exp_l[$];

  int          out_cnt   = 0;
  logic [63:0] last_keep = '0;
  logic        last_last = 1'b0;
  int          exp_trimmed = 0, exp_short = 0, exp_passthru = 0;
  logic        stall_en = 1'b0;

  function automatic logic [63:0] mask_n(input int n);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) m[i] = (i < n);
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Downstream back-pressure, changed just after the clock edge
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge net_clk);
      #1;
      m_axis_tready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Per-cycle compare: every output handshake against the model queue, plus hold stability
  logic         hold_prev = 1'b0;
  logic [577:0] prev_out;
  always @(negedge net_clk) begin
    if (hold_prev) begin
      n_total++;
      if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid} === prev_out) n_pass++;
      else $display("FAIL hold_stable: output changed while stalled (keep %h last %b valid %b)",
                    m_axis_tkeep, m_axis_tlast, m_axis_tvalid);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      out_cnt++;
      last_keep = m_axis_tkeep;
      last_last = m_axis_tlast;
      n_total++;
      if (exp_d.size() == 0) begin
        $display("FAIL extra_beat: got keep %h last %b with no beat expected", m_axis_tkeep, m_axis_tlast);
      end else begin
        if (m_axis_tdata === exp_d[0] && m_axis_tkeep === exp_k[0] && m_axis_tlast === exp_l[0])
          n_pass++;
        else
          $display("FAIL out_beat: got keep %h last %b data %h expected keep %h last %b data %h",
                   m_axis_tkeep, m_axis_tlast, m_axis_tdata, exp_k[0], exp_l[0], exp_d[0]);
        void'(exp_d.pop_front());
        void'(exp_k.pop_front());
        void'(exp_l.pop_front());
      end
    end
    hold_prev = m_axis_tvalid && !m_axis_tready && !sys_reset;
    prev_out  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid};
  end

  task automatic drive_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    int cyc;
    cyc = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    forever begin
      @(negedge net_clk);
      if (s_axis_tready) break;
      cyc++;
      if (cyc > 2000) begin
        $display("FAIL input_accept: beat not accepted after %0d cycles", cyc);
        $fatal(1, "input stuck");
      end
    end
    @(posedge net_clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  // Frame-level model: output is the input truncated at F = 14+L bytes for trimmable frames
  task automatic send_frame(input int n, input logic [15:0] et, input logic [15:0] len,
                            input int max_beats);
    logic [7:0]   fr[256];
    logic [511:0] d;
    logic [63:0]  kin;
    logic         lin, trim;
    int           f, nb, nin, rem, nk;
    for (int i = 0; i < 256; i++) fr[i] = 8'($urandom);
    fr[12] = et[15:8];  fr[13] = et[7:0];
    fr[16] = len[15:8]; fr[17] = len[7:0];
    trim = (et == 16'h0800) && (len >= 16'd20);
    f    = 14 + int'(len);
    nb   = (n + 63) / 64;
    if (max_beats >= nb) begin
      if (!trim) exp_passthru++;
      else if (n < f) exp_short++;
      else if (n > f) exp_trimmed++;
    end
    for (int k = 0; k < nb && k < max_beats; k++) begin
      for (int i = 0; i < 64; i++) d[8*i +: 8] = fr[64*k + i];
      nin = (n - 64*k > 64) ? 64 : n - 64*k;
      kin = mask_n(nin);
      lin = (k == nb - 1);
      if (!trim) begin
        exp_d.push_back(d); exp_k.push_back(kin); exp_l.push_back(lin);
      end else if (64*k < f) begin
        rem = f - 64*k;
        nk  = (rem < nin) ? rem : nin;
        exp_d.push_back(d); exp_k.push_back(mask_n(nk)); exp_l.push_back((rem <= 64) || lin);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge net_clk);
        #1;
      end
      drive_beat(d, kin, lin);
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_d.size() != 0 && cyc < 1000) begin
      @(negedge net_clk);
      cyc++;
    end
    n_total++;
    if (exp_d.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected beats never appeared", exp_d.size());
    repeat (3) @(negedge net_clk);
    @(posedge net_clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, n, typ, l, f;
    sys_reset     = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge net_clk);
    @(negedge net_clk);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_m_tkeep",  m_axis_tkeep,       64'd0);
    chk("rst_m_tlast",  64'(m_axis_tlast),  64'd0);
    chk("rst_m_tdata",  64'(m_axis_tdata != '0), 64'd0);
    @(posedge net_clk);
    #1;
    sys_reset = 1'b0;

    // IPv4 L=28 padded to 60 bytes
    c0 = out_cnt;
    send_frame(60, 16'h0800, 16'd28, 9);
    drain();
    chk("l28_beats", 64'(out_cnt - c0), 64'd1);
    chk("l28_keep",  last_keep, 64'h0000_03FF_FFFF_FFFF);
    chk("l28_last",  64'(last_last), 64'd1);

    // IPv4 L=100 over 64+60 bytes
    c0 = out_cnt;
    send_frame(124, 16'h0800, 16'd100, 9);
    drain();
    chk("l100_beats", 64'(out_cnt - c0), 64'd2);
    chk("l100_keep",  last_keep, 64'h0003_FFFF_FFFF_FFFF);

    // IPv4 L=20 with a whole padding beat to discard
    c0 = out_cnt;
    send_frame(128, 16'h0800, 16'd20, 9);
    drain();
    chk("l20_beats", 64'(out_cnt - c0), 64'd1);
    chk("l20_keep",  last_keep, 64'h0000_0003_FFFF_FFFF);

    // ARP passthrough
    c0 = out_cnt;
    send_frame(60, 16'h0806, 16'd28, 9);
    drain();
    chk("arp_beats", 64'(out_cnt - c0), 64'd1);
    chk("arp_keep",  last_keep, 64'h0FFF_FFFF_FFFF_FFFF);

    // Short IPv4 frame under back-pressure
    stall_en = 1'b1;
    c0 = out_cnt;
    send_frame(128, 16'h0800, 16'd200, 9);
    drain();
    chk("short_beats", 64'(out_cnt - c0), 64'd2);
    chk("short_keep",  last_keep, 64'hFFFF_FFFF_FFFF_FFFF);

    // Exact fit at 64 bytes, then another frame to prove return to IDLE
    c0 = out_cnt;
    send_frame(64, 16'h0800, 16'd50, 9);
    send_frame(60, 16'h0800, 16'd28, 9);
    stall_en = 1'b0;
    drain();
    chk("fit_beats", 64'(out_cnt - c0), 64'd2);

    // Reset while in TRIM after beat0
    send_frame(256, 16'h0800, 16'd200, 1);
    sys_reset = 1'b1;
    @(negedge net_clk);
    chk("rst_mid_s_tready", 64'(s_axis_tready), 64'd0);
    @(posedge net_clk);
    #1;
    sys_reset = 1'b0;
    @(negedge net_clk);
    chk("rst_mid_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    exp_trimmed = 0; exp_short = 0; exp_passthru = 0;
    @(posedge net_clk);
    #1;
    c0 = out_cnt;
    send_frame(60, 16'h0800, 16'd28, 9);
    drain();
    chk("post_rst_keep", last_keep, 64'h0000_03FF_FFFF_FFFF);
    chk("post_rst_beats", 64'(out_cnt - c0), 64'd1);

    // Randomized traffic with random back-pressure
    stall_en = 1'b1;
    for (int fi = 0; fi < 80; fi++) begin
      typ = $urandom_range(0, 3);
      case (typ)
        0: begin
          l = $urandom_range(20, 300);
          f = 14 + l;
          case ($urandom_range(0, 2))
            0: n = f;
            1: n = f + $urandom_range(1, 100);
            default: n = f - $urandom_range(1, 40);
          endcase
          if (n < 18) n = 18;
          if (n > 256) n = 256;
          send_frame(n, 16'h0800, 16'(l), 9);
        end
        1: send_frame($urandom_range(60, 256), 16'($urandom_range(16'h0801, 16'hFFFF)),
                      16'($urandom_range(0, 600)), 9);
        2: send_frame($urandom_range(60, 256), 16'h0800, 16'($urandom_range(0, 19)), 9);
        default: send_frame($urandom_range(60, 130), 16'h0800, 16'($urandom_range(20, 50)), 9);
      endcase
    end
    drain();
    stall_en = 1'b0;

`ifdef ETH_UNPAD_STATS_EN
    chk("stat_trimmed",  64'(stat_trimmed),  64'(exp_trimmed));
    chk("stat_short",    64'(stat_short),    64'(exp_short));
    chk("stat_passthru", 64'(stat_passthru), 64'(exp_passthru));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
